// File: rtl/nn_pkg.sv
// Shared definitions for the nn_lif neuron: config address map, default
// weight/potential types and the signed saturation helper.
package nn_pkg;

    localparam int W_WIDTH_DEF = 8;
    localparam int V_WIDTH_DEF = 16;

    typedef logic signed [W_WIDTH_DEF-1:0] weight_t;
    typedef logic signed [V_WIDTH_DEF-1:0] vpot_t;

    // Config registers sit directly after the N_SYN weight slots.
    localparam int ADDR_OFS_THRESH = 0;
    localparam int ADDR_OFS_LEAK   = 1;
    localparam int ADDR_OFS_REFRAC = 2;

    localparam int SAT_W = 64;

    function automatic int addr_thresh(input int n_syn);
        return n_syn + ADDR_OFS_THRESH;
    endfunction

    function automatic int addr_leak(input int n_syn);
        return n_syn + ADDR_OFS_LEAK;
    endfunction

    function automatic int addr_refrac(input int n_syn);
        return n_syn + ADDR_OFS_REFRAC;
    endfunction

    // Clamp a wide signed value into the signed range of a w-bit word.
    function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] x,
                                                    input int w);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (SAT_W'(1) <<< (w - 1)) - SAT_W'(1);
        lo = -hi - SAT_W'(1);
        if (x > hi)      return hi;
        else if (x < lo) return lo;
        else             return x;
    endfunction

endpackage

// File: rtl/nn_lif_syn_sum.sv
// Combinational weighted sum of the synapse weights whose spike bit is set.
module nn_lif_syn_sum #(
    parameter int N_SYN   = 4,
    parameter int W_WIDTH = 8,
    parameter int SUM_W   = 19
) (
    input  logic [N_SYN-1:0]               spike_i,
    input  logic [N_SYN-1:0][W_WIDTH-1:0]  weight_i,
    output logic signed [SUM_W-1:0]        sum_o
);

    // Accumulate sign-extended weights of the active channels.
    always_comb begin
        sum_o = '0;
        for (int i = 0; i < N_SYN; i++) begin
            if (spike_i[i])
                sum_o = sum_o + $signed({{(SUM_W-W_WIDTH){weight_i[i][W_WIDTH-1]}}, weight_i[i]});
        end
    end

endmodule

// File: rtl/nn_lif.sv
// Leaky integrate-and-fire neuron with per-synapse weights, programmable
// threshold and refractory period. Define NN_LIF_LEAK_EN to add the
// leak_shift register and the V >>> leak_shift leak term.
module nn_lif
    import nn_pkg::*;
#(
    parameter int  N_SYN          = 4,
    parameter int  W_WIDTH        = 8,
    parameter int  V_WIDTH        = 16,
    parameter int  THRESH_DEFAULT = 100,
    localparam int ADDR_W         = $clog2(N_SYN + 3)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_SYN-1:0]          input_spike,
    input  logic                      cfg_valid,
    input  logic [ADDR_W-1:0]         cfg_addr,
    input  logic [V_WIDTH-1:0]        cfg_data,
    output logic                      output_spike,
    output logic signed [V_WIDTH-1:0] membrane,
    output logic [15:0]               spike_count
);

    localparam int SUM_W = V_WIDTH + $clog2(N_SYN) + 1;
    localparam int ACC_W = SUM_W + 1;

    logic [N_SYN-1:0][W_WIDTH-1:0] weight_q;
    logic signed [V_WIDTH-1:0]     thresh_q;
    logic [3:0]                    refrac_q;
    logic signed [V_WIDTH-1:0]     v_q, v_d;
    logic                          spike_q, spike_d;
    logic [3:0]                    rcnt_q, rcnt_d;
    logic [15:0]                   count_q, count_d;

    logic signed [SUM_W-1:0]       syn_sum;
    logic signed [V_WIDTH-1:0]     leak;
    logic signed [ACC_W-1:0]       acc;
    logic signed [V_WIDTH-1:0]     v_next;

    nn_lif_syn_sum #(
        .N_SYN   (N_SYN),
        .W_WIDTH (W_WIDTH),
        .SUM_W   (SUM_W)
    ) u_syn_sum (
        .spike_i  (input_spike),
        .weight_i (weight_q),
        .sum_o    (syn_sum)
    );

`ifdef NN_LIF_LEAK_EN
    logic [3:0] leak_shift_q;

    // A zero shift means "no leak", not "leak everything".
    always_comb leak = (leak_shift_q != 4'd0) ? (v_q >>> leak_shift_q) : '0;
`else
    assign leak = '0;
`endif

    // ACC_W holds V - leak + sum without overflow; clamp back to V_WIDTH.
    assign acc    = ACC_W'(v_q) - ACC_W'(leak) + ACC_W'(syn_sum);
    assign v_next = V_WIDTH'(sat(SAT_W'(acc), V_WIDTH));

    // Next neuron state: refractory hold, fire-and-reset, or integrate.
    always_comb begin
        v_d     = v_q;
        spike_d = 1'b0;
        rcnt_d  = rcnt_q;
        count_d = count_q;
        if (rcnt_q != 4'd0) begin
            v_d    = '0;
            rcnt_d = rcnt_q - 4'd1;
        end else if (v_next >= thresh_q) begin
            spike_d = 1'b1;
            v_d     = '0;
            rcnt_d  = refrac_q;
            count_d = count_q + 16'd1;
        end else begin
            v_d = v_next;
        end
    end

    // Neuron state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q     <= '0;
            spike_q <= 1'b0;
            rcnt_q  <= 4'd0;
            count_q <= 16'd0;
        end else begin
            v_q     <= v_d;
            spike_q <= spike_d;
            rcnt_q  <= rcnt_d;
            count_q <= count_d;
        end
    end

    // Config register writes; the neuron sees new values from the next edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            weight_q     <= '0;
            thresh_q     <= V_WIDTH'(THRESH_DEFAULT);
            refrac_q     <= 4'd0;
`ifdef NN_LIF_LEAK_EN
            leak_shift_q <= 4'd0;
`endif
        end else if (cfg_valid) begin
            for (int i = 0; i < N_SYN; i++) begin
                if (cfg_addr == ADDR_W'(i))
                    weight_q[i] <= cfg_data[W_WIDTH-1:0];
            end
            if (cfg_addr == ADDR_W'(addr_thresh(N_SYN)))
                thresh_q <= cfg_data;
`ifdef NN_LIF_LEAK_EN
            if (cfg_addr == ADDR_W'(addr_leak(N_SYN)))
                leak_shift_q <= cfg_data[3:0];
`endif
            if (cfg_addr == ADDR_W'(addr_refrac(N_SYN)))
                refrac_q <= cfg_data[3:0];
        end
    end

    assign output_spike = spike_q;
    assign membrane     = v_q;
    assign spike_count  = count_q;

endmodule

// File: doc/nn_lif.md
NN_LIF -- requirements
Module: nn_lif

Interface
REQ-001 SHALL provide parameter N_SYN, default 4: number of input synapse channels (2..16).
REQ-002 SHALL provide parameter W_WIDTH, default 8: signed synapse weight width.
REQ-003 SHALL provide parameter V_WIDTH, default 16: signed membrane potential width.
REQ-004 SHALL provide parameter THRESH_DEFAULT, default 100: threshold value loaded at reset.
REQ-005 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port input_spike, input, N_SYN: one spike bit per synapse, sampled each rising edge.
REQ-008 SHALL have port cfg_valid, input, 1: config write strobe.
REQ-009 SHALL have port cfg_addr, input, ADDR_W = $clog2(N_SYN+3): config register address.
REQ-010 SHALL have port cfg_data, input, V_WIDTH: config write data.
REQ-011 SHALL have port output_spike, output, 1: one-cycle spike pulse.
REQ-012 SHALL have port membrane, output, V_WIDTH: current signed potential V.
REQ-013 SHALL have port spike_count, output, 16: total emitted spikes.

Function
REQ-014 SHALL map config addresses: 0..N_SYN-1 weight[i] (low W_WIDTH bits of cfg_data), N_SYN threshold, N_SYN+1 leak_shift (low 4 bits), N_SYN+2 refrac (low 4 bits).
REQ-015 SHALL write on any edge with cfg_valid=1; out-of-range addresses ignored; new value used from the following edge.
REQ-016 SHALL compute per edge: sum = sign-extended sum of weight[i] over i with input_spike[i]=1, at width V_WIDTH+$clog2(N_SYN)+1.
REQ-017 SHALL compute leak = V >>> leak_shift when leak_shift != 0, else 0; V' = saturate(V - leak + sum) to signed V_WIDTH range.
REQ-018 SHALL, when not refractory and V' >= threshold (signed compare): output_spike <= 1, V <= 0, refrac_cnt <= refrac, spike_count <= spike_count+1 (wraps 0xFFFF->0).
REQ-019 SHALL, when not refractory and V' < threshold: V <= V', output_spike <= 0.
REQ-020 SHALL, when refrac_cnt != 0: ignore input_spike, hold V at 0, output_spike <= 0, refrac_cnt decrements by 1.
REQ-021 SHALL make output_spike high for exactly one cycle per crossing; latency one edge from sampled input to output_spike.
REQ-022 SHALL, with refrac=0, allow spikes on consecutive edges.
REQ-023 SHALL treat a simultaneous config write and spike evaluation using the old register values.

Reset
REQ-024 SHALL on reset set V=0, output_spike=0, spike_count=0, refrac_cnt=0, all weights=0, threshold=THRESH_DEFAULT, leak_shift=0, refrac=0.
REQ-025 SHALL abort any refractory period and drop pending state immediately on reset assertion mid-operation.

Configuration
REQ-026 SHALL support macro NN_LIF_LEAK_EN: defined -> leak_shift register and leak term per REQ-017; undefined -> no leak_shift register, leak = 0, writes to address N_SYN+1 ignored.

Structure
REQ-027 SHALL place address constants, weight/potential typedefs and saturation function in shared package nn_pkg.
REQ-028 SHALL implement the weighted-sum adder as sub-module nn_lif_syn_sum (combinational, parameterised by N_SYN, W_WIDTH); state and config registers stay in nn_lif.

Verification
REQ-029 SHALL cover: weight[0]=60, spike ch0 on two consecutive edges -> V=60 then output_spike=1, V=0, spike_count=1.
REQ-030 SHALL cover: refrac=3, threshold=10, weight[1]=20, ch1 held high -> spikes on edges 1,5,9; V=0 in between.
REQ-031 SHALL cover: N_SYN=4, weights 127,127,127,127, threshold=0x7FFF, all channels high -> V saturates at 32767 and spikes; weights -128 all, threshold default -> V saturates at -32768, no spike.
REQ-032 SHALL cover (NN_LIF_LEAK_EN): leak_shift=1, V=64, no input -> V sequence 32,16,8,4,2,1,1.
REQ-033 SHALL cover: reset asserted while refrac_cnt=2 -> all outputs 0 immediately, threshold back to 100.
REQ-034 SHALL cover: cfg write weight[2]=50 on same edge as ch2 spike -> old weight 0 used, 50 used on next spike.
